// File: rtl/tetris_pkg.sv
// Shared Tetris constants, the line-clear FSM state type and the score table.
// Scoring helpers are used only when LINE_CLEAR_SCORE_EN is defined.
package tetris_pkg;

    localparam int ROWS    = 22;
    localparam int COLS    = 10;
    localparam int CNT_W   = 5;
    localparam int SCORE_W = 20;
    localparam int PTR_W   = 5;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lc_state_e;

    localparam logic [SCORE_W-1:0] SCORE_L0 = 20'd0;
    localparam logic [SCORE_W-1:0] SCORE_L1 = 20'd40;
    localparam logic [SCORE_W-1:0] SCORE_L2 = 20'd100;
    localparam logic [SCORE_W-1:0] SCORE_L3 = 20'd300;
    localparam logic [SCORE_W-1:0] SCORE_L4 = 20'd1200;

    function automatic logic [SCORE_W-1:0] score_for(input logic [CNT_W-1:0] lines);
        case (lines)
            5'd0:    return SCORE_L0;
            5'd1:    return SCORE_L1;
            5'd2:    return SCORE_L2;
            5'd3:    return SCORE_L3;
            default: return SCORE_L4;
        endcase
    endfunction

    // Adds with saturation at the all-ones value instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[SCORE_W]) begin
            return {SCORE_W{1'b1}};
        end else begin
            return sum[SCORE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/line_clear_shift.sv
// Combinational row removal: drops row ptr_i, moves rows above it down by one
// and inserts an empty row at the top.
module line_clear_shift
    import tetris_pkg::*;
(
    input  logic [ROWS-1:0][COLS-1:0] grid_i,
    input  logic [PTR_W-1:0]          ptr_i,
    output logic [ROWS-1:0][COLS-1:0] grid_o
);

    // Row 0 always becomes empty; rows at or below the pointer take their upper neighbour.
    always_comb begin
        grid_o = '0;
        for (int r = 1; r < ROWS; r++) begin
            if (PTR_W'(r) <= ptr_i) begin
                grid_o[r] = grid_i[r-1];
            end else begin
                grid_o[r] = grid_i[r];
            end
        end
    end

endmodule

// File: rtl/line_clear.sv
// Line-clear stage: scans a grid snapshot bottom-up, removes full rows and
// publishes the compacted grid. Optional scoring: LINE_CLEAR_SCORE_EN.
module line_clear
    import tetris_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ROWS-1:0][COLS-1:0] grid_in,
    output logic                      busy,
    output logic                      done,
    output logic [ROWS-1:0][COLS-1:0] grid_out,
    output logic [CNT_W-1:0]          lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [SCORE_W-1:0]        score
`endif
);

    lc_state_e                 state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ROWS-1:0][COLS-1:0] work_q, work_d;
    logic [ROWS-1:0][COLS-1:0] grid_out_q, grid_out_d;
    logic [CNT_W-1:0]          lines_q, lines_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [ROWS-1:0][COLS-1:0] shifted_s;
    logic                      row_full_s;
`ifdef LINE_CLEAR_SCORE_EN
    logic [SCORE_W-1:0]        score_q, score_d;
`endif

    line_clear_shift u_shift (
        .grid_i (work_q),
        .ptr_i  (ptr_q),
        .grid_o (shifted_s)
    );

    assign row_full_s = &work_q[ptr_q];

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        grid_out_d = grid_out_q;
        lines_d    = lines_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
        score_d    = score_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    work_d  = grid_in;
                    ptr_d   = PTR_W'(ROWS - 1);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            SCAN: begin
                // A cleared row keeps the pointer so the row shifted into it is re-examined.
                if (row_full_s) begin
                    work_d = shifted_s;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (ptr_q == '0) begin
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    grid_out_d = work_q;
                    lines_d    = cnt_q;
`ifdef LINE_CLEAR_SCORE_EN
                    score_d    = sat_add(score_q, score_for(cnt_q));
`endif
                end else begin
                    ptr_d = ptr_q - PTR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            work_q     <= '0;
            grid_out_q <= '0;
            lines_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
            score_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            grid_out_q <= grid_out_d;
            lines_q    <= lines_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef LINE_CLEAR_SCORE_EN
            score_q    <= score_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign grid_out      = grid_out_q;
    assign lines_cleared = lines_q;
`ifdef LINE_CLEAR_SCORE_EN
    assign score         = score_q;
`endif

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: a cycle-level reference model compared every
// cycle, plus directed literal checks of the test-plan scenarios.
module tb_line_clear;
    import tetris_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [ROWS-1:0][COLS-1:0] grid_in;
    logic                      busy;
    logic                      done;
    logic [ROWS-1:0][COLS-1:0] grid_out;
    logic [CNT_W-1:0]          lines_cleared;
    logic [SCORE_W-1:0]        score_v;
`ifdef LINE_CLEAR_SCORE_EN
    logic [SCORE_W-1:0]        score;
    assign score_v = score;
`else
    assign score_v = '0;
`endif

    line_clear dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .grid_in       (grid_in),
        .busy          (busy),
        .done          (done),
        .grid_out      (grid_out),
        .lines_cleared (lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
        ,
        .score         (score)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int st_cyc = 0;
    int done_pulses = 0;
    int last_lat = -1;
    int busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: keep non-full rows in order, packed against the bottom.
    function automatic void compact(input grid_t g, output grid_t o, output int l);
        int dst;
        o = '0;
        l = 0;
        dst = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (g[r] == {COLS{1'b1}}) begin
                l++;
            end else begin
                o[dst] = g[r];
                dst--;
            end
        end
    endfunction

    function automatic logic [SCORE_W-1:0] ref_points(input int l);
        if (l == 0)      return 20'd0;
        else if (l == 1) return 20'd40;
        else if (l == 2) return 20'd100;
        else if (l == 3) return 20'd300;
        else             return 20'd1200;
    endfunction

    // Model state
    logic  m_busy, m_done, m_active;
    grid_t m_grid, m_pend;
    int    m_lines, m_pend_l, m_k;
    longint m_score;

    initial begin
        logic was_done;
        m_busy = 1'b0; m_done = 1'b0; m_active = 1'b0;
        m_grid = '0; m_pend = '0; m_lines = 0; m_pend_l = 0; m_k = 0; m_score = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_busy = 1'b0; m_done = 1'b0; m_active = 1'b0;
                m_grid = '0; m_lines = 0; m_score = 0;
            end else begin
                was_done = m_done;
                m_done = 1'b0;
                if (m_active) begin
                    m_k++;
                    if (m_k == ROWS + m_pend_l) begin
                        m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                        m_grid = m_pend; m_lines = m_pend_l;
                        m_score = m_score + ref_points(m_pend_l);
                        if (m_score > 64'd1048575) m_score = 64'd1048575;
                    end
                end else if (start && !was_done) begin
                    m_active = 1'b1; m_busy = 1'b1; m_k = 0;
                    compact(grid_in, m_pend, m_pend_l);
                end
            end
            @(negedge clk);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("grid_out", grid_out, m_grid);
            check("lines_cleared", lines_cleared, m_lines);
`ifdef LINE_CLEAR_SCORE_EN
            check("score", score_v, m_score);
`endif
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_pulses++;
                last_lat = cyc - st_cyc;
            end
        end
    end

    // Pulses start with g, optionally a second (ignored) start at cycle extra_at, and waits for done.
    task automatic run(input grid_t g, input int extra_at, input int exp_lat);
        int n;
        @(negedge clk);
        grid_in = g; start = 1'b1; st_cyc = cyc; busy_cnt = 0;
        n = done_pulses;
        for (int i = 1; i < 70; i++) begin
            @(negedge clk);
            start = (i == extra_at) ? 1'b1 : 1'b0;
            #1;
            if (done_pulses != n) break;
        end
        check("done_seen", done_pulses - n, 1);
        check("latency", last_lat, exp_lat);
        repeat (4) @(negedge clk);
        check("single_done", done_pulses - n, 1);
    endtask

    grid_t g, e;
    int n0;

    initial begin
        reset = 1'b1; start = 1'b0; grid_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_grid", grid_out, 256'd0);
        check("rst_lines", lines_cleared, 5'd0);
        check("rst_score", score_v, 20'd0);

        // Empty grid
        g = '0;
        run(g, 0, 23);
        check("t1_busy_cycles", busy_cnt, 22);
        check("t1_lines", lines_cleared, 5'd0);
        check("t1_grid", grid_out, 256'd0);

        // One full bottom row
        g = '0; g[21] = 10'h3FF; g[20] = 10'h001;
        run(g, 0, 24);
        e = '0; e[21] = 10'h001;
        check("t2_lines", lines_cleared, 5'd1);
        check("t2_grid", grid_out, e);
        check("t2_busy_cycles", busy_cnt, 23);
`ifdef LINE_CLEAR_SCORE_EN
        check("t2_score", score_v, 20'd40);
`endif

        // Four adjacent full rows
        g = '0; g[21] = 10'h3FF; g[20] = 10'h3FF; g[19] = 10'h3FF; g[18] = 10'h3FF; g[17] = 10'h155;
        run(g, 0, 27);
        e = '0; e[21] = 10'h155;
        check("t3_lines", lines_cleared, 5'd4);
        check("t3_grid", grid_out, e);
`ifdef LINE_CLEAR_SCORE_EN
        check("t3_score", score_v, 20'd1240);
`endif

        // Non-adjacent full rows
        g = '0; g[21] = 10'h3FF; g[20] = 10'h00F; g[19] = 10'h3FF; g[5] = 10'h200;
        run(g, 0, 25);
        e = '0; e[21] = 10'h00F; e[7] = 10'h200;
        check("t4_lines", lines_cleared, 5'd2);
        check("t4_grid", grid_out, e);

        // Fully set grid with a stray start at cycle 10
        g = '1;
        run(g, 10, 45);
        check("t5_lines", lines_cleared, 5'd22);
        check("t5_grid", grid_out, 256'd0);
`ifdef LINE_CLEAR_SCORE_EN
        check("t5_score", score_v, 20'd2540);
`endif

        // Reset in cycle 5 of a scan
        g = '0; g[21] = 10'h3FF; g[20] = 10'h001;
        @(negedge clk);
        grid_in = g; start = 1'b1; st_cyc = cyc;
        n0 = done_pulses;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_grid", grid_out, 256'd0);
        check("t6_lines", lines_cleared, 5'd0);
        check("t6_score", score_v, 20'd0);
        repeat (30) @(negedge clk);
        check("t6_no_done", done_pulses - n0, 0);

        g = '0; g[21] = 10'h3FF; g[20] = 10'h3FF; g[19] = 10'h3FF; g[18] = 10'h3FF; g[17] = 10'h155;
        run(g, 0, 27);
        e = '0; e[21] = 10'h155;
        check("t6_lines_after", lines_cleared, 5'd4);
        check("t6_grid_after", grid_out, e);
`ifdef LINE_CLEAR_SCORE_EN
        check("t6_score_after", score_v, 20'd1200);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
